// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the instruction/data memory arbiter.
package mem_arb_pkg;

  localparam int unsigned MEM_ARB_ADDR_W = 32;
  localparam int unsigned MEM_ARB_DATA_W = 32;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    NONE   = 2'd0,
    IFETCH = 2'd1,
    DATA   = 2'd2
  } owner_e;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection for the memory arbiter.
// MEM_ARB_RR_EN: round-robin tie-break; otherwise the data port wins ties.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic   i_ireq,
  input  logic   i_dreq,
  input  logic   i_lock_vld,
  input  owner_e i_lock_own,
`ifdef MEM_ARB_RR_EN
  input  owner_e i_rr_last,
`endif
  output owner_e o_winner
);

  // A locked winner keeps the port only while it still holds its request.
  always_comb begin
    o_winner = NONE;
    if (i_lock_vld && i_lock_own == IFETCH && i_ireq) begin
      o_winner = IFETCH;
    end else if (i_lock_vld && i_lock_own == DATA && i_dreq) begin
      o_winner = DATA;
    end else if (i_ireq && i_dreq) begin
`ifdef MEM_ARB_RR_EN
      o_winner = (i_rr_last == DATA) ? IFETCH : DATA;
`else
      o_winner = DATA;
`endif
    end else if (i_dreq) begin
      o_winner = DATA;
    end else if (i_ireq) begin
      o_winner = IFETCH;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto a single memory port, one transaction outstanding.
// MEM_ARB_RR_EN: round-robin tie-break; default build uses fixed data-first priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = MEM_ARB_ADDR_W,
  parameter int unsigned DATA_W = MEM_ARB_DATA_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_gnt,
  output logic                i_rvalid,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wstrb,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                err
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam logic [ADDR_W-1:0] ADDR_MASK = ~(ADDR_W'(3));

  state_e r_state;
  owner_e r_owner;
  logic   r_lock_vld;
  owner_e r_lock_own;
  logic   r_err;
`ifdef MEM_ARB_RR_EN
  owner_e r_rr_last;
`endif

  owner_e w_winner;
  logic   w_issue;
  logic   w_accept;
  logic   w_resp;

  mem_arb_pick u_pick (
    .i_ireq     (i_req),
    .i_dreq     (d_req),
    .i_lock_vld (r_lock_vld),
    .i_lock_own (r_lock_own),
`ifdef MEM_ARB_RR_EN
    .i_rr_last  (r_rr_last),
`endif
    .o_winner   (w_winner)
  );

  // Memory-port drive and handshake steering; all gated off while rst is high.
  always_comb begin
    w_issue   = !rst && (r_state == IDLE) && (w_winner != NONE);
    w_accept  = w_issue && mem_gnt;
    w_resp    = !rst && (r_state == BUSY) && mem_rvalid;
    mem_req   = w_issue;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = STRB_W'(0);
    if (w_issue) begin
      if (w_winner == DATA) begin
        mem_we    = d_we;
        mem_addr  = d_addr & ADDR_MASK;
        mem_wdata = d_wdata;
        mem_wstrb = d_wstrb;
      end else begin
        mem_addr  = i_addr & ADDR_MASK;
      end
    end
    i_gnt    = w_accept && (w_winner == IFETCH);
    d_gnt    = w_accept && (w_winner == DATA);
    i_rvalid = w_resp && (r_owner == IFETCH);
    d_rvalid = w_resp && (r_owner == DATA);
  end

  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;
  assign err     = r_err;

  // Transaction FSM: issue/lock in IDLE, wait for the single response in BUSY.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_owner    <= NONE;
      r_lock_vld <= 1'b0;
      r_lock_own <= NONE;
      r_err      <= 1'b0;
`ifdef MEM_ARB_RR_EN
      r_rr_last  <= IFETCH;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (mem_rvalid) begin
            r_err <= 1'b1;
          end
          if (w_accept) begin
            r_state    <= BUSY;
            r_owner    <= w_winner;
            r_lock_vld <= 1'b0;
            r_lock_own <= NONE;
`ifdef MEM_ARB_RR_EN
            r_rr_last  <= w_winner;
`endif
          end else if (w_issue) begin
            r_lock_vld <= 1'b1;
            r_lock_own <= w_winner;
          end else begin
            r_lock_vld <= 1'b0;
            r_lock_own <= NONE;
          end
        end
        BUSY: begin
          if (mem_rvalid) begin
            r_state <= IDLE;
            r_owner <= NONE;
          end
        end
        default: begin
          r_state <= IDLE;
          r_owner <= NONE;
        end
      endcase
    end
  end

endmodule
